// File: rtl/instr_enc_pkg.sv
// Shared definitions for the instruction encoder: symbolic op codes,
// MIPS32 opcode/funct/sa constants, FSM states and word-format helpers.
package instr_enc_pkg;

    typedef enum logic [4:0] {
        OP_RTYPE = 5'd0,
        OP_MUL,
        OP_SEB,
        OP_SEH,
        OP_ANDI,
        OP_ORI,
        OP_XORI,
        OP_ADDI,
        OP_ADDIU,
        OP_SLTI,
        OP_SLTIU,
        OP_LUI,
        OP_LW,
        OP_LB,
        OP_LH,
        OP_SW,
        OP_SB,
        OP_SH,
        OP_BGTZ,
        OP_BLEZ,
        OP_BLTZ,
        OP_BGEZ,
        OP_BEQ,
        OP_BNE,
        OP_J,
        OP_JAL = 5'd25
    } instr_op_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DONE
    } enc_state_t;

    // Primary 6-bit opcodes
    localparam logic [5:0] OPC_SPECIAL  = 6'b000000;
    localparam logic [5:0] OPC_REGIMM   = 6'b000001;
    localparam logic [5:0] OPC_J        = 6'b000010;
    localparam logic [5:0] OPC_JAL      = 6'b000011;
    localparam logic [5:0] OPC_BEQ      = 6'b000100;
    localparam logic [5:0] OPC_BNE      = 6'b000101;
    localparam logic [5:0] OPC_BLEZ     = 6'b000110;
    localparam logic [5:0] OPC_BGTZ     = 6'b000111;
    localparam logic [5:0] OPC_ADDI     = 6'b001000;
    localparam logic [5:0] OPC_ADDIU    = 6'b001001;
    localparam logic [5:0] OPC_SLTI     = 6'b001010;
    localparam logic [5:0] OPC_SLTIU    = 6'b001011;
    localparam logic [5:0] OPC_ANDI     = 6'b001100;
    localparam logic [5:0] OPC_ORI      = 6'b001101;
    localparam logic [5:0] OPC_XORI     = 6'b001110;
    localparam logic [5:0] OPC_LUI      = 6'b001111;
    localparam logic [5:0] OPC_SPECIAL2 = 6'b011100;
    localparam logic [5:0] OPC_SPECIAL3 = 6'b011111;
    localparam logic [5:0] OPC_LB       = 6'b100000;
    localparam logic [5:0] OPC_LH       = 6'b100001;
    localparam logic [5:0] OPC_LW       = 6'b100011;
    localparam logic [5:0] OPC_SB       = 6'b101000;
    localparam logic [5:0] OPC_SH       = 6'b101001;
    localparam logic [5:0] OPC_SW       = 6'b101011;

    // Secondary fields
    localparam logic [5:0] FN_MUL    = 6'b000010;
    localparam logic [5:0] FN_BSHFL  = 6'b100000;
    localparam logic [4:0] SA_SEB    = 5'b10000;
    localparam logic [4:0] SA_SEH    = 5'b11000;
    localparam logic [4:0] RT_BLTZ   = 5'b00000;
    localparam logic [4:0] RT_BGEZ   = 5'b00001;

    function automatic logic [31:0] enc_r(input logic [5:0] opc, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [4:0] rd,
                                          input logic [4:0] sa, input logic [5:0] fn);
        return {opc, rs, rt, rd, sa, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] opc, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {opc, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_j(input logic [5:0] opc, input logic [25:0] tgt);
        return {opc, tgt};
    endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational descriptor-to-word packer. Fields not used by an op are
// forced to zero; undefined op codes report Legal=0 with a zero word.
module instr_pack
    import instr_enc_pkg::*;
(
    input  logic [4:0]  op,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [4:0]  shamt,
    input  logic [5:0]  funct,
    input  logic [15:0] imm16,
    input  logic [25:0] target,
    output logic [31:0] word,
    output logic        legal
);

    // Select the instruction format and constant fields for each op
    always_comb begin
        word  = '0;
        legal = 1'b1;
        case (op)
            OP_RTYPE: word = enc_r(OPC_SPECIAL,  rs,    rt, rd, shamt,  funct);
            OP_MUL:   word = enc_r(OPC_SPECIAL2, rs,    rt, rd, 5'd0,   FN_MUL);
            OP_SEB:   word = enc_r(OPC_SPECIAL3, 5'd0,  rt, rd, SA_SEB, FN_BSHFL);
            OP_SEH:   word = enc_r(OPC_SPECIAL3, 5'd0,  rt, rd, SA_SEH, FN_BSHFL);
            OP_ANDI:  word = enc_i(OPC_ANDI,  rs, rt, imm16);
            OP_ORI:   word = enc_i(OPC_ORI,   rs, rt, imm16);
            OP_XORI:  word = enc_i(OPC_XORI,  rs, rt, imm16);
            OP_ADDI:  word = enc_i(OPC_ADDI,  rs, rt, imm16);
            OP_ADDIU: word = enc_i(OPC_ADDIU, rs, rt, imm16);
            OP_SLTI:  word = enc_i(OPC_SLTI,  rs, rt, imm16);
            OP_SLTIU: word = enc_i(OPC_SLTIU, rs, rt, imm16);
            OP_LUI:   word = enc_i(OPC_LUI,   5'd0, rt, imm16);
            OP_LW:    word = enc_i(OPC_LW,    rs, rt, imm16);
            OP_LB:    word = enc_i(OPC_LB,    rs, rt, imm16);
            OP_LH:    word = enc_i(OPC_LH,    rs, rt, imm16);
            OP_SW:    word = enc_i(OPC_SW,    rs, rt, imm16);
            OP_SB:    word = enc_i(OPC_SB,    rs, rt, imm16);
            OP_SH:    word = enc_i(OPC_SH,    rs, rt, imm16);
            OP_BGTZ:  word = enc_i(OPC_BGTZ,  rs, 5'd0, imm16);
            OP_BLEZ:  word = enc_i(OPC_BLEZ,  rs, 5'd0, imm16);
            OP_BLTZ:  word = enc_i(OPC_REGIMM, rs, RT_BLTZ, imm16);
            OP_BGEZ:  word = enc_i(OPC_REGIMM, rs, RT_BGEZ, imm16);
            OP_BEQ:   word = enc_i(OPC_BEQ,   rs, rt, imm16);
            OP_BNE:   word = enc_i(OPC_BNE,   rs, rt, imm16);
            OP_J:     word = enc_j(OPC_J,   target);
            OP_JAL:   word = enc_j(OPC_JAL, target);
            default:  legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder: accepts descriptors over valid/ready during a load
// session and writes packed words to consecutive instruction-memory
// addresses through a one-cycle registered write stage.
module instr_encoder
    import instr_enc_pkg::*;
#(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DEPTH  = 256
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              Start,
    input  logic [ADDR_W-1:0] BaseAddr,
    input  logic              InValid,
    output logic              InReady,
    input  logic [4:0]        Op,
    input  logic [4:0]        Rs,
    input  logic [4:0]        Rt,
    input  logic [4:0]        Rd,
    input  logic [4:0]        Shamt,
    input  logic [5:0]        Funct,
    input  logic [15:0]       Imm16,
    input  logic [25:0]       Target,
    input  logic              Last,
    output logic              IMWrEn,
    output logic [ADDR_W-1:0] IMWrAddr,
    output logic [31:0]       IMWrData,
    output logic              Busy,
    output logic              Done,
    output logic [ADDR_W:0]   Count,
    output logic              IllegalOp,
    output logic              Overflow
);

    enc_state_t        state;
    logic [ADDR_W-1:0] wrptr;
    logic [31:0]       word;
    logic              legal;
    logic              accept;
    logic              at_end;

    instr_pack u_pack (
        .op     (Op),
        .rs     (Rs),
        .rt     (Rt),
        .rd     (Rd),
        .shamt  (Shamt),
        .funct  (Funct),
        .imm16  (Imm16),
        .target (Target),
        .word   (word),
        .legal  (legal)
    );

    assign accept = InValid && (state == ST_LOAD);
    assign at_end = (wrptr == ADDR_W'(DEPTH - 1));

    // Status outputs decode directly from the state register
    assign InReady = (state == ST_LOAD);
    assign Busy    = (state != ST_IDLE);
    assign Done    = (state == ST_DONE);

    // Session FSM, write pointer, counters and the write-stage register
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state     <= ST_IDLE;
            wrptr     <= '0;
            Count     <= '0;
            IllegalOp <= 1'b0;
            Overflow  <= 1'b0;
            IMWrEn    <= 1'b0;
            IMWrAddr  <= '0;
            IMWrData  <= '0;
        end else begin
            IMWrEn <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (Start) begin
                        state     <= ST_LOAD;
                        wrptr     <= BaseAddr;
                        Count     <= '0;
                        IllegalOp <= 1'b0;
                        Overflow  <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (accept) begin
                        if (legal) begin
                            IMWrEn   <= 1'b1;
                            IMWrAddr <= wrptr;
                            IMWrData <= word;
                            Count    <= Count + (ADDR_W + 1)'(1);
                            // Pointer holds at the last address so it never wraps
                            if (at_end) begin
                                state    <= ST_DONE;
                                Overflow <= ~Last;
                            end else begin
                                wrptr <= wrptr + ADDR_W'(1);
                                if (Last) state <= ST_DONE;
                            end
                        end else begin
                            IllegalOp <= 1'b1;
                            if (Last) state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Inverse of the main controller's opcode decode. Accepts symbolic instruction descriptors (op code plus register and immediate fields) over a valid/ready stream and assembles the 32-bit MIPS32 word.
- Writes the assembled words to consecutive instruction-memory addresses through a one-cycle registered write stage.
- Used by the bench and the boot loader to build programs that the decode path consumes.

Parameters:
ADDR_W, 8, instruction-memory word-address width
DEPTH, 256, words in instruction memory; must equal 2**ADDR_W

Ports:
Clk  in  1  clock, rising edge
Rst_n  in  1  asynchronous active-low reset
Start  in  1  one-cycle pulse; begins a load session (honoured in IDLE only)
BaseAddr  in  ADDR_W  first write address, sampled on Start
InValid  in  1  descriptor valid
InReady  out  1  descriptor accepted when InValid && InReady
Op  in  5  instr_op_t code
Rs, Rt, Rd, Shamt  in  5 each  register/shift fields
Funct  in  6  funct field, used by OP_RTYPE only
Imm16  in  16  immediate or branch offset
Target  in  26  jump target
Last  in  1  marks the final descriptor of the session
IMWrEn  out  1  instruction-memory write strobe
IMWrAddr  out  ADDR_W  write address
IMWrData  out  32  encoded instruction
Busy  out  1  state != IDLE
Done  out  1  one-cycle pulse ending the session
Count  out  ADDR_W+1  words written this session
IllegalOp  out  1  sticky; set on an undefined Op code
Overflow  out  1  sticky; memory end reached before Last

Behaviour:
- Reset: state=IDLE; all outputs 0. A reset during LOAD drops any pending write; IMWrEn is 0 while Rst_n=0.
- FSM states are IDLE, LOAD and DONE.
  - IDLE→LOAD on Start. On that edge: WrPtr=BaseAddr, Count=0, IllegalOp=0, Overflow=0.
  - Start is ignored in LOAD and DONE.
  - LOAD→DONE on an accepted descriptor with Last=1, or on a legal accept at WrPtr==DEPTH-1.
  - DONE→IDLE unconditionally after one cycle. Done=1 only in DONE.
- InReady=1 only in LOAD. There is no memory backpressure, so throughput is one descriptor per cycle.
- Latency for a legal accept in cycle N:
  - In N+1: IMWrEn=1, IMWrAddr=WrPtr(N), IMWrData=encoded word.
  - WrPtr and Count increment at the N/N+1 edge.
  - If that accept also ends the session, Done and the write coincide in N+1.
- Illegal Op (codes 26-31):
  - The descriptor is accepted and consumed.
  - No write; WrPtr and Count are unchanged; IllegalOp is set.
  - Last still ends the session.
- Overflow:
  - A legal accept at WrPtr==DEPTH-1 with Last=0 is written, then Overflow=1 and the FSM goes to DONE.
  - Addresses never wrap. With Last=1 at the same point, Overflow stays 0.
- Encoding is {op6, rs, rt, rd, sa, funct} or {op6, rs, rt, imm16} or {op6, target26}. Every field not listed for an op is forced to 0.
  - RTYPE: op 000000, rs, rt, rd, Shamt, Funct.
  - MUL: op 011100, rs, rt, rd, funct 000010.
  - SEB/SEH: op 011111, rs=0, rt, rd, sa 10000 (SEB) or 11000 (SEH), funct 100000.
  - ANDI/ORI/XORI/ADDI/ADDIU/SLTI/SLTIU: op 001100/001101/001110/001000/001001/001010/001011; rs, rt, imm.
  - LUI: op 001111; rs=0, rt, imm.
  - LW/LB/LH/SW/SB/SH: op 100011/100000/100001/101011/101000/101001; base rs, rt, imm.
  - BGTZ/BLEZ: op 000111/000110; rs, rt=0, imm.
  - BLTZ/BGEZ: op 000001; rs, rt=00000 or 00001, imm.
  - BEQ/BNE: op 000100/000101; rs, rt, imm.
  - J/JAL: op 000010/000011; Target.

Decomposition:
- Package instr_enc_pkg holds:
  - instr_op_t, 5-bit: RTYPE=0, MUL, SEB, SEH, ANDI, ORI, XORI, ADDI, ADDIU, SLTI, SLTIU, LUI, LW, LB, LH, SW, SB, SH, BGTZ, BLEZ, BLTZ, BGEZ, BEQ, BNE, J, JAL=25.
  - The 6-bit opcode/funct constants and the SEB/SEH sa constants.
- Sub-module instr_pack (combinational): descriptor → {Word, Legal}. The top level holds the FSM, pointer, counters and the write-stage register.

Test Plan:
- Base=0x00; ADDI Rs=1 Rt=2 Imm=0x0005, Last=1 → next cycle IMWrEn=1, Addr=0x00, Data=0x20220005, Done=1, Count=1.
- Stream BGEZ Rs=3 Imm=0xFFFE then BLTZ with the same fields (Last on the second), Base=0x10 → 0x0461FFFE @0x10, 0x0460FFFE @0x11, back-to-back cycles.
- SEH Rt=4 Rd=5; SEB same; JAL Target=0x0000010 → 0x7C042E20, 0x7C042C20, 0x0C000010; Rs input garbage is ignored for SEB/SEH.
- Base=0xFE; three legal descriptors, none Last → writes @0xFE and @0xFF, Overflow=1, Done, InReady=0, third descriptor not accepted, Count=2.
- Op=26 between two ADDIs → two writes at consecutive addresses, IllegalOp=1, Count=2; a new Start clears IllegalOp.
- Assert Rst_n low the cycle after an accept → no IMWrEn, all outputs 0, FSM in IDLE; Start pulsed during LOAD has no effect.
